// File: rtl/adc_gen_pkg.sv
// rtl/adc_gen_pkg.sv - shared encodings and constants for the ADC pattern generator
package adc_gen_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP    = 2'd0,
        MODE_FIXED   = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_PRBS    = 2'd3
    } adc_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } gen_state_e;

    // Fibonacci taps for x^16+x^15+x^13+x^4+1, shifting toward the MSB
    localparam logic [15:0] LFSR_TAPS  = 16'hD008;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] CHECKER_A  = 16'hAAAA;
    localparam logic [15:0] CHECKER_B  = 16'h5555;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/adc_pattern_src.sv
// rtl/adc_pattern_src.sv - per-mode pattern state; advances only the selected generator
module adc_pattern_src
    import adc_gen_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    advance,
    input  logic [1:0]              mode,
    input  logic [SAMPLE_WIDTH-1:0] fixed_value,
    output logic [SAMPLE_WIDTH-1:0] base
);

    adc_mode_e               mode_e;
    logic [SAMPLE_WIDTH-1:0] ramp_q;
    logic                    phase_q;
    logic [15:0]             lfsr_q;

    assign mode_e = adc_mode_e'(mode);

    always_comb begin
        base = ramp_q;
        case (mode_e)
            MODE_RAMP:    base = ramp_q;
            MODE_FIXED:   base = fixed_value;
            MODE_CHECKER: base = phase_q ? CHECKER_B[SAMPLE_WIDTH-1:0] : CHECKER_A[SAMPLE_WIDTH-1:0];
            MODE_PRBS:    base = lfsr_q[SAMPLE_WIDTH-1:0];
            default:      base = ramp_q;
        endcase
    end

    // The current value is consumed on the advance edge, so each state steps after use
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ramp_q  <= '0;
            phase_q <= 1'b0;
            lfsr_q  <= LFSR_SEED;
        end else if (advance) begin
            case (mode_e)
                MODE_RAMP:    ramp_q  <= ramp_q + SAMPLE_WIDTH'(1);
                MODE_CHECKER: phase_q <= ~phase_q;
                MODE_PRBS:    lfsr_q  <= lfsr_next(lfsr_q);
                default:      ;
            endcase
        end
    end

endmodule

// File: rtl/adc_pattern_gen.sv
// rtl/adc_pattern_gen.sv - multi-channel serial ADC emulator with framed test patterns
module adc_pattern_gen
    import adc_gen_pkg::*;
#(
    parameter int NUM_CHANNELS = 2,
    parameter int SAMPLE_WIDTH = 12,
    parameter int LANES        = 2,
    parameter int FRAME_BITS   = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enable,
    input  logic [1:0]                           mode,
    input  logic [SAMPLE_WIDTH-1:0]              fixed_value,
    output logic [NUM_CHANNELS*LANES-1:0]        lane_out,
    output logic                                 dco_out,
    output logic                                 fr_out,
    output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] sample_out,
    output logic                                 sample_strobe,
    output logic                                 busy
);

    localparam int BW      = $clog2(FRAME_BITS);
    localparam int PERIODS = SAMPLE_WIDTH / LANES;

    gen_state_e                            state_q, state_d;
    logic [BW-1:0]                         bit_q, bit_d;
    logic                                  load;
    logic [SAMPLE_WIDTH-1:0]               base;
    logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0]  sample_d;
    logic [NUM_CHANNELS*LANES-1:0]         lane_d;
    logic [SAMPLE_WIDTH-1:0]               shifted;
    logic                                  fr_d, dco_d, strobe_d;

    adc_pattern_src #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_src (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance     (load),
        .mode        (mode),
        .fixed_value (fixed_value),
        .base        (base)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                    bit_d   = '0;
                end
            end
            ST_RUN: begin
                // enable is only looked at on the last period so frames are never cut short
                if (int'(bit_q) == FRAME_BITS - 1) begin
                    bit_d = '0;
                    if (enable) load = 1'b1;
                    else        state_d = ST_IDLE;
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        sample_d = sample_out;
        if (load) begin
            for (int c = 0; c < NUM_CHANNELS; c++)
                sample_d[c*SAMPLE_WIDTH +: SAMPLE_WIDTH] = (c % 2 == 0) ? base : ~base;
        end

        lane_d   = '0;
        shifted  = '0;
        fr_d     = 1'b0;
        dco_d    = 1'b0;
        strobe_d = 1'b0;
        if (state_d == ST_RUN) begin
            fr_d     = int'(bit_d) < FRAME_BITS / 2;
            dco_d    = bit_d[0];
            strobe_d = load;
            if (int'(bit_d) < PERIODS) begin
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    shifted = sample_d[c*SAMPLE_WIDTH +: SAMPLE_WIDTH] << (LANES * int'(bit_d));
                    for (int l = 0; l < LANES; l++)
                        lane_d[c*LANES + l] = shifted[SAMPLE_WIDTH-1-l];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bit_q         <= '0;
            lane_out      <= '0;
            dco_out       <= 1'b0;
            fr_out        <= 1'b0;
            sample_out    <= '0;
            sample_strobe <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_q         <= bit_d;
            lane_out      <= lane_d;
            dco_out       <= dco_d;
            fr_out        <= fr_d;
            sample_out    <= sample_d;
            sample_strobe <= strobe_d;
            busy          <= (state_d == ST_RUN);
        end
    end

endmodule

// File: tb/tb_adc_pattern_gen.sv
// tb/tb_adc_pattern_gen.sv - directed self-checking bench for adc_pattern_gen
module tb_adc_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic [11:0] fixed_value;
    logic [3:0]  lane_out;
    logic        dco_out, fr_out, sample_strobe, busy;
    logic [23:0] sample_out;

    logic        en1;
    logic [1:0]  mode1;
    logic [11:0] fixed1;
    logic [0:0]  lane1;
    logic        dco1, fr1, strobe1, busy1;
    logic [11:0] sample1;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    adc_pattern_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .mode          (mode),
        .fixed_value   (fixed_value),
        .lane_out      (lane_out),
        .dco_out       (dco_out),
        .fr_out        (fr_out),
        .sample_out    (sample_out),
        .sample_strobe (sample_strobe),
        .busy          (busy)
    );

    adc_pattern_gen #(
        .NUM_CHANNELS (1),
        .SAMPLE_WIDTH (12),
        .LANES        (1),
        .FRAME_BITS   (14)
    ) dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (en1),
        .mode          (mode1),
        .fixed_value   (fixed1),
        .lane_out      (lane1),
        .dco_out       (dco1),
        .fr_out        (fr1),
        .sample_out    (sample1),
        .sample_strobe (strobe1),
        .busy          (busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0]  e_l0, e_l1, e_c1, e_fr;
        logic [11:0] r;
        e_l0 = 8'b11111000;
        e_l1 = 8'b00011000;
        e_c1 = 8'b00000100;
        e_fr = 8'b11110000;

        rst_n = 1'b0; enable = 1'b0; mode = 2'd0; fixed_value = 12'h000;
        en1 = 1'b0; mode1 = 2'd1; fixed1 = 12'h800;
        repeat (3) tick();
        chk("rst_lane", lane_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fr", fr_out, 0);
        chk("rst_strobe", sample_strobe, 0);
        chk("rst_sample", sample_out, 0);

        // Fixed 0xABC frame; enable dropped at period 3, fixed_value changed mid-frame
        rst_n = 1'b1; mode = 2'd1; fixed_value = 12'hABC; enable = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk("fix_l0", lane_out[0], e_l0[7-k]);
            chk("fix_l1", lane_out[1], e_l1[7-k]);
            chk("fix_c1l0", lane_out[2], e_c1[7-k]);
            chk("fix_fr", fr_out, e_fr[7-k]);
            chk("fix_dco", dco_out, k % 2);
            chk("fix_strobe", sample_strobe, k == 0);
            chk("fix_busy", busy, 1);
            if (k == 0 || k == 5) chk("fix_sample", sample_out, 24'h543ABC);
            if (k == 2) fixed_value = 12'h123;
            if (k == 3) enable = 1'b0;
            if (k < 7) tick();
        end
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_lane", lane_out, 0);
        chk("idle_fr", fr_out, 0);
        chk("idle_dco", dco_out, 0);
        chk("idle_strobe", sample_strobe, 0);
        chk("idle_hold", sample_out, 24'h543ABC);

        // Ramp through wrap; frames must be back-to-back every 8 cycles
        mode = 2'd0; enable = 1'b1;
        tick();
        for (int f = 0; f < 4100; f++) begin
            r = f[11:0];
            chk("ramp_sample", sample_out, {~r, r});
            chk("ramp_strobe", sample_strobe, 1);
            for (int k = 1; k < 8; k++) begin
                tick();
                if (f == 4099 && k == 3) enable = 1'b0;
            end
            tick();
        end
        chk("ramp_idle_busy", busy, 0);
        chk("ramp_idle_lane", lane_out, 0);
        tick();
        enable = 1'b1;
        tick();
        chk("ramp_resume", sample_out, 24'hFFB004);

        // Mode change mid-frame only affects the following frames
        repeat (2) tick();
        mode = 2'd2;
        repeat (3) tick();
        chk("mode_mid", sample_out, 24'hFFB004);
        repeat (3) tick();
        chk("chk_a", sample_out, 24'h555AAA);
        repeat (8) tick();
        chk("chk_b", sample_out, 24'hAAA555);
        repeat (8) tick();
        chk("chk_a2", sample_out, 24'h555AAA);
        repeat (7) tick();
        mode = 2'd3;
        tick();
        chk("prbs_0", sample_out, 24'h31ECE1);
        repeat (8) tick();
        chk("prbs_1", sample_out, 24'h63C9C3);

        // Reset mid-frame at period 4
        repeat (4) tick();
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        chk("mrst_lane", lane_out, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_fr", fr_out, 0);
        chk("mrst_dco", dco_out, 0);
        chk("mrst_sample", sample_out, 0);
        rst_n = 1'b1;
        tick();
        chk("prbs_after_rst", sample_out, 24'h31ECE1);
        repeat (7) tick();
        mode = 2'd2;
        tick();
        chk("chk_after_rst", sample_out, 24'h555AAA);
        enable = 1'b0;
        repeat (8) tick();
        chk("end_busy", busy, 0);

        // Single-lane, 14-period frame with fixed 0x800
        en1 = 1'b1;
        tick();
        chk("l1_sample", sample1, 12'h800);
        for (int k = 0; k < 14; k++) begin
            chk("l1_lane", lane1, k == 0);
            chk("l1_fr", fr1, k < 7);
            chk("l1_busy", busy1, 1);
            if (k == 0) en1 = 1'b0;
            tick();
        end
        chk("l1_idle", busy1, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
